// File: rtl/demux_dispatch_ctrl.sv
// Single-word dispatch controller: holds one source word and hands it to one of
// four demux lanes chosen round-robin, abandoning a lane that does not ack in time.
module demux_dispatch_ctrl #(
  parameter int DATA_WIDTH = 1,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            req,
  input  logic [3:0]            ack,
  output logic [1:0]            select,
  output logic                  enable,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARB      = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t                state, state_next;
  logic [1:0]            select_next;
  logic [1:0]            last, last_next;
  logic [DATA_WIDTH-1:0] data_next;
  logic [7:0]            count, count_next;
  logic                  enable_next;
  logic                  terr_next;
  logic                  grant_valid;
  logic [1:0]            grant_lane;

  // Rotating priority starting after the last served lane; scanning from the
  // farthest candidate down lets the nearest requester overwrite the result.
  always_comb begin
    grant_valid = 1'b0;
    grant_lane  = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      if (req[2'(last + 2'(k))]) begin
        grant_valid = 1'b1;
        grant_lane  = 2'(last + 2'(k));
      end
    end
  end

  always_comb begin
    state_next  = state;
    select_next = select;
    last_next   = last;
    data_next   = data_out;
    count_next  = count;
    enable_next = 1'b0;
    terr_next   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          data_next  = in_data;
          state_next = ARB;
        end
      end
      ARB: begin
        if (grant_valid) begin
          select_next = grant_lane;
          count_next  = 8'd0;
          enable_next = 1'b1;
          state_next  = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        enable_next = 1'b1;
        if (ack[select]) begin
          last_next   = select;
          enable_next = 1'b0;
          state_next  = IDLE;
        end else begin
          count_next = count + 8'd1;
          if (count + 8'd1 == TIMEOUT_C) begin
            terr_next   = 1'b1;
            last_next   = select;
            enable_next = 1'b0;
            state_next  = ARB;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      select      <= 2'd0;
      last        <= 2'd3;
      data_out    <= '0;
      count       <= 8'd0;
      enable      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      select      <= select_next;
      last        <= last_next;
      data_out    <= data_next;
      count       <= count_next;
      enable      <= enable_next;
      timeout_err <= terr_next;
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Directed bench for demux_dispatch_ctrl; a word-level model tracks the held word,
// the lane it is presented to and the wait time, and is compared after every edge.
module tb_demux_dispatch_ctrl;

  localparam int DW  = 8;
  localparam int TMO = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    req = 4'd0;
  logic [3:0]    ack = 4'd0;
  logic [1:0]    select;
  logic          enable;
  logic [DW-1:0] data_out;
  logic          busy;
  logic          timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: word held or not, lane currently presented (-1 = none), cycles waited.
  bit  m_hold;
  int  m_word;
  int  m_lane;
  int  m_waited;
  int  m_last;
  int  m_sel;
  bit  m_terr;

  demux_dispatch_ctrl #(.DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .req(req), .ack(ack), .select(select),
    .enable(enable), .data_out(data_out), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hold = 0; m_word = 0; m_lane = -1; m_waited = 0;
    m_last = 3; m_sel = 0; m_terr = 0;
  endtask

  task automatic model_step();
    int l;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_terr = 0;
    if (!m_hold) begin
      if (in_valid) begin
        m_hold = 1;
        m_word = int'(in_data);
      end
    end else if (m_lane < 0) begin
      for (int k = 1; k <= 4; k++) begin
        l = (m_last + k) % 4;
        if (m_lane < 0 && req[l]) begin
          m_lane = l; m_sel = l; m_waited = 0;
        end
      end
    end else begin
      if (ack[m_lane]) begin
        m_last = m_lane; m_hold = 0; m_lane = -1;
      end else if (m_waited + 1 == TMO) begin
        m_terr = 1; m_last = m_lane; m_lane = -1;
      end else begin
        m_waited++;
      end
    end
  endtask

  task automatic compare_all();
    chk("in_ready", int'(in_ready), int'(!m_hold));
    chk("busy", int'(busy), int'(m_hold));
    chk("enable", int'(enable), int'(m_lane >= 0));
    chk("select", int'(select), m_sel);
    chk("data_out", int'(data_out), m_word);
    chk("timeout_err", int'(timeout_err), int'(m_terr));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    $display("t=%0t in_v=%0b req=%b ack=%b -> rdy=%0b busy=%0b en=%0b sel=%0d data=%0h terr=%0b",
             $time, in_valid, req, ack, in_ready, busy, enable, select, data_out, timeout_err);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; req = 4'd0; ack = 4'd0;
    #1;
    model_reset();
    compare_all();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Accept one word and grant it against the given request vector.
  task automatic offer(input int word, input logic [3:0] r);
    in_data = DW'(word); in_valid = 1'b1; req = r;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    model_reset();
    do_reset();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_select", int'(select), 0);

    // Single word to lane 2
    offer(1, 4'b0100);
    chk("single_select", int'(select), 2);
    chk("single_enable", int'(enable), 1);
    chk("single_data", int'(data_out), 1);
    ack = 4'b0100;
    tick();
    ack = 4'b0000;
    chk("single_enable_off", int'(enable), 0);
    chk("single_ready", int'(in_ready), 1);

    // Round-robin from reset: 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 5; i++) begin
      offer(8'h10 + i, 4'b1111);
      chk("rr_grant", int'(select), i % 4);
      ack = 4'b0001 << select;
      tick();
      ack = 4'b0000;
    end

    // Timeout on lane 1, regrant to lane 0 with the same word
    do_reset();
    offer(8'hA5, 4'b0010);
    chk("tmo_grant", int'(select), 1);
    req = 4'b0011;
    tick();
    tick();
    chk("tmo_still_waiting", int'(enable), 1);
    chk("tmo_no_err_yet", int'(timeout_err), 0);
    tick();
    chk("tmo_err", int'(timeout_err), 1);
    chk("tmo_enable_off", int'(enable), 0);
    chk("tmo_busy", int'(busy), 1);
    tick();
    chk("tmo_err_pulse", int'(timeout_err), 0);
    chk("tmo_regrant", int'(select), 0);
    chk("tmo_data_kept", int'(data_out), 8'hA5);
    ack = 4'b0001;
    tick();
    ack = 4'b0000;

    // Ack on the last allowed cycle wins over timeout
    offer(8'h3C, 4'b0100);
    tick();
    tick();
    ack = 4'b0100;
    tick();
    ack = 4'b0000;
    chk("race_no_err", int'(timeout_err), 0);
    chk("race_idle", int'(in_ready), 1);

    // Acks from other lanes are ignored
    offer(8'h5A, 4'b0001);
    ack = 4'b1110;
    tick();
    chk("foreign_ack_wait", int'(enable), 1);
    tick();
    ack = 4'b0000;
    tick();
    chk("foreign_then_tmo", int'(timeout_err), 1);
    tick();
    ack = 4'b0001;
    tick();
    ack = 4'b0000;

    // No requesters for ten cycles
    offer(8'hC3, 4'b0000);
    for (int i = 0; i < 9; i++) tick();
    chk("noreq_enable", int'(enable), 0);
    chk("noreq_ready", int'(in_ready), 0);
    chk("noreq_busy", int'(busy), 1);
    req = 4'b1000;
    tick();
    chk("noreq_select", int'(select), 3);
    ack = 4'b1000;
    tick();
    ack = 4'b0000; req = 4'b0000;

    // Asynchronous reset during WAIT_ACK
    offer(8'h77, 4'b0100);
    chk("arst_waiting", int'(enable), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_enable", int'(enable), 0);
    chk("arst_ready", int'(in_ready), 1);
    chk("arst_data", int'(data_out), 0);
    model_reset();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    offer(8'h99, 4'b1111);
    chk("arst_first_grant", int'(select), 0);
    ack = 4'b0001;
    tick();
    ack = 4'b0000; req = 4'b0000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demux_dispatch_ctrl.md
DEMUX_DISPATCH_CTRL -- requirements
Module: demux_dispatch_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_WIDTH  1   width of the dispatched data word
  TIMEOUT     15  maximum WAIT_ACK cycles before abandoning a lane; legal range 1..255
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk          in   1           single clock; all state on rising edge
  rst_n        in   1           asynchronous, active-low reset
  in_data      in   DATA_WIDTH  word from source
  in_valid     in   1           source offers in_data
  in_ready     out  1           controller can accept a word
  req          in   4           lane n (0..3) can take a word
  ack          in   4           lane n has consumed the word
  select       out  2           demux lane select (0=a, 1=b, 2=c, 3=d)
  enable       out  1           demux enable
  data_out     out  DATA_WIDTH  held word driven to the demux input
  busy         out  1           a word is held
  timeout_err  out  1           one-cycle pulse: granted lane timed out
REQ-003 The design SHALL use one clock, clk; rst_n SHALL be asynchronous and active-low.

Function
REQ-004 The FSM SHALL have three states: IDLE (empty), ARB (word held, no grant), WAIT_ACK (word presented to the granted lane).
REQ-005 in_ready SHALL be 1 only in IDLE; busy SHALL be 1 in ARB and WAIT_ACK.
REQ-006 IDLE: if in_valid=1, the controller SHALL latch in_data into data_out and enter ARB on the next edge; otherwise it SHALL stay in IDLE.
REQ-007 ARB: if req != 0, the controller SHALL grant the first requesting lane in order (last+1, last+2, last+3, last) mod 4, register it onto select, and enter WAIT_ACK; if req = 0, it SHALL stay in ARB.
REQ-008 enable SHALL be registered and SHALL equal 1 exactly while in WAIT_ACK; select and data_out SHALL stay stable throughout WAIT_ACK.
REQ-009 WAIT_ACK: if ack[select]=1, the controller SHALL set last := select and enter IDLE; enable SHALL be 0 on the following cycle.
REQ-010 ack bits of non-granted lanes SHALL be ignored; req SHALL be ignored outside ARB.
REQ-011 A timeout counter SHALL clear on entry to WAIT_ACK and increment once per WAIT_ACK cycle without a qualifying ack.
REQ-012 When the counter reaches TIMEOUT with no ack, the controller SHALL pulse timeout_err for one cycle, set last := select, and return to ARB while retaining the word, so the next grant skips the failed lane first.
REQ-013 If ack[select] arrives in the same cycle the counter reaches TIMEOUT, the ack SHALL win: no timeout_err, transition to IDLE.
REQ-014 select and data_out SHALL hold their last values while not in WAIT_ACK.
REQ-015 Latency: in_valid accepted at edge k -> grant at edge k+1 (if req != 0) -> enable=1 from edge k+1 until the ack edge; minimum accept-to-IDLE is 3 edges.
REQ-016 The counter width SHALL be 8 bits; no wrap-around is possible within the legal TIMEOUT range.

Reset
REQ-017 While rst_n=0, the controller SHALL immediately drive: state=IDLE, in_ready=1, busy=0, enable=0, select=0, data_out=0, timeout_err=0, counter=0, last=3 (so lane 0 has first priority).
REQ-018 Reset asserted mid-operation SHALL drop any held word and force enable=0 without waiting for a clock edge.

Verification
REQ-019 Single word, DATA_WIDTH=1: in_data=1, in_valid=1, req=4'b0100 -> next cycle select=2, enable=1, data_out=1; ack=4'b0100 -> IDLE, enable=0, in_ready=1.
REQ-020 Round-robin: req=4'b1111 held, four words each acked after 1 cycle -> grants in order 0,1,2,3, then 0 again for a fifth word.
REQ-021 Timeout, TIMEOUT=3: grant lane 1, ack=0 -> exactly 3 WAIT_ACK cycles, then timeout_err=1 for 1 cycle and ARB; with req=4'b0011, the next grant is lane 0 and data_out is unchanged.
REQ-022 Simultaneous events: ack[select] asserted on the TIMEOUT-th cycle -> IDLE, timeout_err stays 0; ack on a non-granted lane only -> no transition.
REQ-023 No requesters: a word is accepted with req=0 for 10 cycles -> controller stays in ARB, enable=0, in_ready=0, busy=1; req=4'b1000 -> select=3.
REQ-024 Async reset: rst_n pulled low between clock edges during WAIT_ACK -> enable=0 and in_ready=1 before the next edge; after release, the first grant with req=4'b1111 is lane 0.
